execute_mc: RTL and testbench

//  Parametrised multi-cycle execute stage; successor to the fixed 16-bit single-phase execute stage.

---
 rtl/execute_mc.sv | 221 ++++++++++++++++++++++
 tb/tb_execute_mc.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/execute_mc.sv
// Multi-cycle execute stage: operand select, single-cycle ALU, iterative shifter, valid/ready on both sides.
// Optional feature: define EXEC_MUL_EN for a shift-add multiplier on op 12.
`timescale 1ns/1ps
module execute_mc #(
    parameter int WIDTH   = 16,
    parameter int IMM_W   = 8,
    parameter int SHAMT_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op_src_a,
    input  logic [1:0]         op_src_b,
    input  logic [3:0]         op_alu,
    input  logic               op_out_update,
    input  logic [WIDTH-1:0]   ar,
    input  logic [WIDTH-1:0]   br,
    input  logic [WIDTH-1:0]   pc,
    input  logic [WIDTH-1:0]   ir,
    input  logic [WIDTH-1:0]   ext_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [3:0]         szcv,
    output logic [WIDTH-1:0]   data_for_output
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SLR = 4'd9;
    localparam logic [3:0] OP_SRL = 4'd10;
    localparam logic [3:0] OP_SRA = 4'd11;

    logic [1:0]         state;
    logic [WIDTH-1:0]   a_reg;
    logic [SHAMT_W-1:0] count;
    logic [3:0]         op_reg;

    logic [WIDTH-1:0]   opa, opb;
    logic [WIDTH:0]     sum, diff;
    logic [WIDTH-1:0]   alu_res, flag_val;
    logic               alu_c, alu_v;
    logic [3:0]         alu_flags;
    logic [WIDTH-1:0]   shift_next;
    logic               shift_out;
    logic               is_shift;
    logic [SHAMT_W-1:0] shamt;
    logic               unused_ir_bits;

    assign unused_ir_bits = &{1'b0, ir[WIDTH-1:IMM_W]};

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_HOLD);

    always_comb begin
        case (op_src_a)
            2'd0:    opa = br;
            2'd1:    opa = ext_in;
            2'd2:    opa = pc;
            default: opa = '0;
        endcase
        case (op_src_b)
            2'd0:    opb = {{(WIDTH-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
            2'd1:    opb = {{(WIDTH-SHAMT_W){1'b0}}, ir[SHAMT_W-1:0]};
            2'd2:    opb = ar;
            default: opb = '0;
        endcase
    end

    assign sum      = {1'b0, opa} + {1'b0, opb};
    assign diff     = {1'b0, opa} - {1'b0, opb};
    assign is_shift = (op_alu[3:2] == 2'b10);
    assign shamt    = opb[SHAMT_W-1:0];

    // CMP reports the flags of a-b while passing a through as the result
    always_comb begin
        alu_res = opa;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_alu)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = (op_alu == OP_SUB) ? diff[WIDTH-1:0] : opa;
                alu_c   = diff[WIDTH];
                alu_v   = (opa[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            OP_XOR:  alu_res = opa ^ opb;
            OP_MOV:  alu_res = opb;
            OP_NOT:  alu_res = ~opb;
            default: alu_res = opa;
        endcase
        flag_val  = (op_alu == OP_CMP) ? diff[WIDTH-1:0] : alu_res;
        alu_flags = {flag_val[WIDTH-1], (flag_val == '0), alu_c, alu_v};
    end

    always_comb begin
        shift_next = a_reg;
        shift_out  = 1'b0;
        case (op_reg)
            OP_SLL: begin shift_next = {a_reg[WIDTH-2:0], 1'b0};         shift_out = a_reg[WIDTH-1]; end
            OP_SLR: begin shift_next = {a_reg[WIDTH-2:0], a_reg[WIDTH-1]}; shift_out = a_reg[WIDTH-1]; end
            OP_SRL: begin shift_next = {1'b0, a_reg[WIDTH-1:1]};         shift_out = a_reg[0]; end
            OP_SRA: begin shift_next = {a_reg[WIDTH-1], a_reg[WIDTH-1:1]}; shift_out = a_reg[0]; end
            default: begin shift_next = a_reg; shift_out = 1'b0; end
        endcase
    end

`ifdef EXEC_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd12;
    localparam int         MCW    = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mul_a, mul_acc, mul_acc_next;
    logic [WIDTH-1:0]   mul_b;
    logic [MCW-1:0]     mul_cnt;

    assign mul_acc_next = mul_acc + (mul_b[0] ? mul_a : '0);
`endif

    // Operands are captured only on accept; BUSY works purely from internal registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= ST_IDLE;
            result          <= '0;
            szcv            <= '0;
            data_for_output <= '0;
            a_reg           <= '0;
            count           <= '0;
            op_reg          <= '0;
`ifdef EXEC_MUL_EN
            mul_a           <= '0;
            mul_b           <= '0;
            mul_acc         <= '0;
            mul_cnt         <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_reg <= op_alu;
                        if (op_out_update)
                            data_for_output <= ar;
                        if (is_shift) begin
                            if (shamt == '0) begin
                                result <= opa;
                                szcv   <= {opa[WIDTH-1], (opa == '0), 2'b00};
                                state  <= ST_HOLD;
                            end else begin
                                a_reg <= opa;
                                count <= shamt;
                                state <= ST_BUSY;
                            end
                        end
`ifdef EXEC_MUL_EN
                        else if (op_alu == OP_MUL) begin
                            mul_a   <= {{WIDTH{1'b0}}, opa};
                            mul_b   <= opb;
                            mul_acc <= '0;
                            mul_cnt <= MCW'(WIDTH);
                            state   <= ST_BUSY;
                        end
`endif
                        else begin
                            result <= alu_res;
                            szcv   <= alu_flags;
                            state  <= ST_HOLD;
                        end
                    end
                end
                ST_BUSY: begin
`ifdef EXEC_MUL_EN
                    if (op_reg == OP_MUL) begin
                        mul_acc <= mul_acc_next;
                        mul_a   <= {mul_a[2*WIDTH-2:0], 1'b0};
                        mul_b   <= {1'b0, mul_b[WIDTH-1:1]};
                        mul_cnt <= mul_cnt - MCW'(1);
                        if (mul_cnt == MCW'(1)) begin
                            result <= mul_acc_next[WIDTH-1:0];
                            szcv   <= {mul_acc_next[WIDTH-1], (mul_acc_next[WIDTH-1:0] == '0),
                                       (|mul_acc_next[2*WIDTH-1:WIDTH]), 1'b0};
                            state  <= ST_HOLD;
                        end
                    end else
`endif
                    begin
                        a_reg <= shift_next;
                        count <= count - SHAMT_W'(1);
                        if (count == SHAMT_W'(1)) begin
                            result <= shift_next;
                            szcv   <= {shift_next[WIDTH-1], (shift_next == '0), shift_out, 1'b0};
                            state  <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_mc.sv
// Directed bench for execute_mc: ALU ops, flags, iterative shifts, HOLD back-pressure, reset mid-shift.
`timescale 1ns/1ps
module tb_execute_mc;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op_src_a;
    logic [1:0]  op_src_b;
    logic [3:0]  op_alu;
    logic        op_out_update;
    logic [15:0] ar, br, pc, ir, ext_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  szcv;
    logic [15:0] data_for_output;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    execute_mc dut (
        .clock           (clock),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .op_src_a        (op_src_a),
        .op_src_b        (op_src_b),
        .op_alu          (op_alu),
        .op_out_update   (op_out_update),
        .ar              (ar),
        .br              (br),
        .pc              (pc),
        .ir              (ir),
        .ext_in          (ext_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .result          (result),
        .szcv            (szcv),
        .data_for_output (data_for_output)
    );

    task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Presents one operation at a negedge; returns at the next negedge (first cycle after accept)
    task automatic apply_stimulus(input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] alu,
                                  input logic upd, input logic [15:0] v_br, input logic [15:0] v_ar,
                                  input logic [15:0] v_pc, input logic [15:0] v_ir, input logic [15:0] v_ext);
        op_src_a      = sa;
        op_src_b      = sb;
        op_alu        = alu;
        op_out_update = upd;
        br            = v_br;
        ar            = v_ar;
        pc            = v_pc;
        ir            = v_ir;
        ext_in        = v_ext;
        in_valid      = 1'b1;
        @(negedge clock);
        in_valid      = 1'b0;
        op_out_update = 1'b0;
    endtask

    task automatic expect_busy(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check_output({tag, " busy out_valid"}, 16'(out_valid), 16'h0);
            check_output({tag, " busy in_ready"}, 16'(in_ready), 16'h0);
            @(negedge clock);
        end
    endtask

    // Checks the HOLD cycle, then with out_ready=1 expects IDLE on the next cycle
    task automatic expect_result(input string tag, input logic [15:0] res, input logic [3:0] flags);
        check_output({tag, " out_valid"}, 16'(out_valid), 16'h1);
        check_output({tag, " result"}, result, res);
        check_output({tag, " szcv"}, 16'(szcv), 16'(flags));
        @(negedge clock);
        check_output({tag, " back to idle"}, 16'(in_ready), 16'h1);
    endtask

    initial begin
        reset         = 1'b0;
        in_valid      = 1'b0;
        out_ready     = 1'b1;
        op_src_a      = 2'd0;
        op_src_b      = 2'd0;
        op_alu        = 4'd0;
        op_out_update = 1'b0;
        ar = '0; br = '0; pc = '0; ir = '0; ext_in = '0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check_output("reset result", result, 16'h0);
        check_output("reset szcv", 16'(szcv), 16'h0);
        check_output("reset out_valid", 16'(out_valid), 16'h0);
        check_output("reset in_ready", 16'(in_ready), 16'h1);
        check_output("reset dfo", data_for_output, 16'h0);
        reset = 1'b1;
        @(negedge clock);

        apply_stimulus(2'd0, 2'd0, 4'd0, 1'b1, 16'h7FFF, 16'hABCD, 16'h0, 16'h0001, 16'h0);
        check_output("add dfo", data_for_output, 16'hABCD);
        expect_result("add", 16'h8000, 4'b1001);

        apply_stimulus(2'd0, 2'd2, 4'd1, 1'b0, 16'h0005, 16'h0005, 16'h0, 16'h0, 16'h0);
        check_output("sub dfo held", data_for_output, 16'hABCD);
        expect_result("sub", 16'h0000, 4'b0100);

        apply_stimulus(2'd0, 2'd2, 4'd5, 1'b0, 16'h0003, 16'h0005, 16'h0, 16'h0, 16'h0);
        expect_result("cmp", 16'h0003, 4'b1010);

        apply_stimulus(2'd1, 2'd0, 4'd4, 1'b1, 16'h0, 16'h1357, 16'h0, 16'h00F0, 16'h00FF);
        check_output("xor dfo", data_for_output, 16'h1357);
        expect_result("xor", 16'hFF0F, 4'b1000);

        apply_stimulus(2'd0, 2'd3, 4'd7, 1'b0, 16'h1111, 16'h0, 16'h0, 16'h0, 16'h0);
        expect_result("not", 16'hFFFF, 4'b1000);

        apply_stimulus(2'd2, 2'd3, 4'd0, 1'b0, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0);
        expect_result("add zero b", 16'hFFFF, 4'b1000);

        apply_stimulus(2'd2, 2'd2, 4'd14, 1'b0, 16'h0, 16'h5555, 16'h1234, 16'h0, 16'h0);
        expect_result("op14 pass a", 16'h1234, 4'b0000);

        out_ready = 1'b0;
        apply_stimulus(2'd0, 2'd1, 4'd11, 1'b0, 16'h8004, 16'h0, 16'h0, 16'h0003, 16'h0);
        expect_busy("sra", 3);
        for (int i = 0; i < 5; i++) begin
            check_output("hold out_valid", 16'(out_valid), 16'h1);
            check_output("hold in_ready", 16'(in_ready), 16'h0);
            check_output("hold result", result, 16'hF000);
            check_output("hold szcv", 16'(szcv), 16'b1010);
            @(negedge clock);
        end
        out_ready = 1'b1;
        @(negedge clock);
        check_output("release in_ready", 16'(in_ready), 16'h1);
        check_output("release out_valid", 16'(out_valid), 16'h0);

        apply_stimulus(2'd0, 2'd1, 4'd8, 1'b0, 16'h8001, 16'h0, 16'h0, 16'h0001, 16'h0);
        expect_busy("sll1", 1);
        expect_result("sll1", 16'h0002, 4'b0010);

        apply_stimulus(2'd0, 2'd1, 4'd9, 1'b0, 16'hF001, 16'h0, 16'h0, 16'h0004, 16'h0);
        expect_busy("rol4", 4);
        expect_result("rol4", 16'h001F, 4'b0010);

        apply_stimulus(2'd0, 2'd1, 4'd10, 1'b0, 16'h0003, 16'h0, 16'h0, 16'h0002, 16'h0);
        expect_busy("srl2", 2);
        expect_result("srl2", 16'h0000, 4'b0110);

        apply_stimulus(2'd0, 2'd1, 4'd10, 1'b0, 16'h9234, 16'h0, 16'h0, 16'h0000, 16'h0);
        expect_result("srl0", 16'h9234, 4'b1000);

        apply_stimulus(2'd0, 2'd1, 4'd11, 1'b0, 16'h8004, 16'h0, 16'h0, 16'h0008, 16'h0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check_output("midreset in_ready", 16'(in_ready), 16'h1);
        check_output("midreset result", result, 16'h0);
        for (int i = 0; i < 12; i++) begin
            check_output("midreset no out_valid", 16'(out_valid), 16'h0);
            @(negedge clock);
        end

`ifdef EXEC_MUL_EN
        apply_stimulus(2'd0, 2'd2, 4'd12, 1'b0, 16'h0012, 16'h0034, 16'h0, 16'h0, 16'h0);
        expect_busy("mul", 16);
        expect_result("mul", 16'h03A8, 4'b0000);
`else
        apply_stimulus(2'd2, 2'd2, 4'd12, 1'b0, 16'h0, 16'h0034, 16'h8000, 16'h0, 16'h0);
        expect_result("op12 pass a", 16'h8000, 4'b1000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
